// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl
//   Trap / interrupt sequencer sitting just upstream of the CSR file in
//   writeback. It watches retiring instructions and the machine interrupt
//   lines. When a trap or MRET is due, it drives the CSR file's update inputs
//   for exactly one cycle, flushes younger work and redirects fetch to the
//   trap vector (trap) or to mepc (MRET).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   commit_valid/pc/exc/cause/mret   retiring instruction in writeback
//   next_pc                          PC of oldest not-yet-retired instruction
//   pipe_idle                        no memory ops in flight; safe to redirect
//   irq_sw, irq_tmr, irq_ext         level interrupt lines (MSIP/MTIP/MEIP)
//   csr_mstatus_mie, csr_mie,
//   csr_mtvec, csr_mepc, mode        current CSR / privilege state
//   st_csr, trap_pc, trap_code,
//   csr_en                           CSR file update (valid in TAKE only)
//   stall_req, flush                 pipeline control
//   redirect_valid/pc/ready          fetch redirect handshake
//   dbg_state                        current FSM state (0 IDLE, 1 DRAIN,
//                                    2 TAKE, 3 REDIRECT)
//
// Redirect handshake: redirect_valid rises in REDIRECT and stays high, with
// redirect_pc held constant, until the cycle in which redirect_ready is
// sampled high. The transfer completes on that clock edge.
// ----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_exc,
    input  logic [3:0]      commit_cause,
    input  logic            commit_mret,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pipe_idle,
    input  logic            irq_sw,
    input  logic            irq_tmr,
    input  logic            irq_ext,
    input  logic            csr_mstatus_mie,
    input  logic [XLEN-1:0] csr_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic [1:0]      mode,
    output logic [1:0]      st_csr,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] trap_code,
    output logic            csr_en,
    output logic            stall_req,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_TAKE     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] STCSR_NONE  = 2'b00;
    localparam logic [1:0] STCSR_ERROR = 2'b01;
    localparam logic [1:0] STCSR_MRET  = 2'b10;

    state_t r_state;
    state_t w_next;

    // Event latches: captured when the event is accepted, consumed in TAKE.
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_code;
    logic            r_is_mret;
    logic [XLEN-1:0] r_target;

    // Load strobes produced by the next-state logic.
    logic w_ld_exc;
    logic w_ld_mret;
    logic w_ld_irq;
    logic w_ld_tgt;

    // ------------------------------------------------------------------
    // Interrupt qualification
    // ------------------------------------------------------------------
    logic       w_ext;
    logic       w_sw;
    logic       w_tmr;
    logic       w_irq_en;
    logic       w_irq_pend;
    logic [3:0] w_irq_cause;

    assign w_ext      = irq_ext & csr_mie[11];
    assign w_sw       = irq_sw  & csr_mie[3];
    assign w_tmr      = irq_tmr & csr_mie[7];
    // Below M-mode, interrupts are always globally enabled.
    assign w_irq_en   = csr_mstatus_mie | (mode != 2'b11);
    assign w_irq_pend = w_irq_en & (w_ext | w_sw | w_tmr);

    // Fixed priority: external > software > timer.
    always_comb begin
        w_irq_cause = 4'd7;
        if (w_ext) begin
            w_irq_cause = 4'd11;
        end else if (w_sw) begin
            w_irq_cause = 4'd3;
        end
    end

    // ------------------------------------------------------------------
    // Trap target
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_trap_tgt;

    assign w_trap_base = {csr_mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off   = {{(XLEN-6){1'b0}}, r_code[3:0], 2'b00};
    // Vectored mode applies to interrupts only; exceptions use the base.
    assign w_trap_tgt  = ((csr_mtvec[1:0] == 2'b01) && r_code[XLEN-1])
                         ? (w_trap_base + w_vec_off) : w_trap_base;

    // Only a handful of mie bits are architecturally meaningful here.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, csr_mie[XLEN-1:12], csr_mie[10:8],
                             csr_mie[6:4], csr_mie[2:0]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        w_ld_exc       = 1'b0;
        w_ld_mret      = 1'b0;
        w_ld_irq       = 1'b0;
        w_ld_tgt       = 1'b0;
        st_csr         = STCSR_NONE;
        trap_pc        = '0;
        trap_code      = '0;
        csr_en         = 1'b0;
        stall_req      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        unique case (r_state)
            S_IDLE: begin
                // Exception beats MRET beats interrupt. A pending interrupt
                // that loses here is seen again once we come back to IDLE.
                if (commit_valid && commit_exc) begin
                    w_ld_exc = 1'b1;
                    w_next   = S_TAKE;
                end else if (commit_valid && commit_mret) begin
                    w_ld_mret = 1'b1;
                    w_next    = S_TAKE;
                end else if (w_irq_pend) begin
                    w_next = S_DRAIN;
                end
            end

            S_DRAIN: begin
                stall_req = 1'b1;
                // A dropped interrupt cancels the drain without any CSR update.
                if (!w_irq_pend) begin
                    w_next = S_IDLE;
                end else if (pipe_idle) begin
                    w_ld_irq = 1'b1;
                    w_next   = S_TAKE;
                end
            end

            S_TAKE: begin
                csr_en    = 1'b1;
                flush     = 1'b1;
                stall_req = 1'b1;
                st_csr    = r_is_mret ? STCSR_MRET : STCSR_ERROR;
                trap_pc   = r_pc;
                trap_code = r_code;
                // Capture the target now: mepc is still the pre-update value.
                w_ld_tgt  = 1'b1;
                w_next    = S_REDIRECT;
            end

            S_REDIRECT: begin
                stall_req      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                if (redirect_ready) begin
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_code    <= '0;
            r_is_mret <= 1'b0;
            r_target  <= '0;
        end else begin
            if (w_ld_exc) begin
                r_pc      <= commit_pc;
                r_code    <= {{(XLEN-4){1'b0}}, commit_cause};
                r_is_mret <= 1'b0;
            end else if (w_ld_mret) begin
                r_pc      <= commit_pc;
                r_code    <= '0;
                r_is_mret <= 1'b1;
            end else if (w_ld_irq) begin
                r_pc      <= next_pc;
                r_code    <= {1'b1, {(XLEN-5){1'b0}}, w_irq_cause};
                r_is_mret <= 1'b0;
            end
            if (w_ld_tgt) begin
                r_target <= r_is_mret ? csr_mepc : w_trap_tgt;
            end
        end
    end

    assign dbg_state = r_state;

    // The pipeline must not retire anything while frozen.
    a_no_commit_in_stall : assert property (
        @(posedge clk) disable iff (!rst_n) stall_req |-> !commit_valid
    );

endmodule
